// File: rtl/spr_bist_pkg.sv
// Shared constants and state encoding for the single-port RAM BIST controller.
package spr_bist_pkg;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int ERR_W  = 5;
  localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_W1, S_R1, S_FIN
  } state_t;
endpackage

// File: rtl/spr_bist_ctrl_if.sv
// Control/result and memory-port bundle between the BIST controller and its RAM/host.
interface spr_bist_ctrl_if
  import spr_bist_pkg::*;
#(
  parameter int DATA_W = spr_bist_pkg::DATA_W
);
  logic              start;
  logic [DATA_W-1:0] pattern;
  logic              mem_WEN;
  logic [ADDR_W-1:0] mem_Addr;
  logic [DATA_W-1:0] mem_Data;
  logic [DATA_W-1:0] mem_Q;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] fail_addr;

  modport master (
    input  start, pattern, mem_Q,
    output mem_WEN, mem_Addr, mem_Data, busy, done, pass, err_count, fail_addr
  );
  modport slave (
    output start, pattern, mem_Q,
    input  mem_WEN, mem_Addr, mem_Data, busy, done, pass, err_count, fail_addr
  );
endinterface

// File: rtl/bist_addr_gen.sv
// Up/down address counter with synchronous load; terminal count depends on direction.
module bist_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int LAST   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_en,
  input  logic              i_up,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_addr <= '0;
    else if (i_load) r_addr <= i_load_val;
    else if (i_en)   r_addr <= i_up ? r_addr + 1'b1 : r_addr - 1'b1;
  end

  assign o_addr = r_addr;
  assign o_tc   = i_up ? (r_addr == LAST_A) : (r_addr == '0);
endmodule

// File: rtl/spr_bist_ctrl.sv
// March-style BIST: write/read background, then write/read inverse, with a
// one-cycle compare pipeline matching the RAM's registered read data.
module spr_bist_ctrl #(
  parameter int DEPTH  = spr_bist_pkg::DEPTH,
  parameter int DATA_W = spr_bist_pkg::DATA_W
) (
  input  logic           CLK,
  input  logic           RST,
  spr_bist_ctrl_if.master bus
);
  import spr_bist_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic              r_drain, r_first, r_cmp_vld;
  logic              r_wen, r_busy, r_done, r_pass;
  logic [DATA_W-1:0] r_pat, r_data, r_exp_data;
  logic [ADDR_W-1:0] r_exp_addr, r_fail;
  logic [ERR_W-1:0]  r_err;

  logic              w_ld, w_en, w_up, w_tc, w_miss;
  logic [ADDR_W-1:0] w_ld_val, w_addr;
  logic [ERR_W-1:0]  w_err_nxt;

  assign w_up = (r_state == S_W0) || (r_state == S_R0);

  // Counter is parked at 0 outside a run, so mem_Addr reads 0 in IDLE/FIN.
  always_comb begin
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_en     = 1'b0;
    unique case (r_state)
      S_W0:    if (w_tc) w_ld = 1'b1; else w_en = 1'b1;
      S_R0:    if (w_tc) begin w_ld = 1'b1; w_ld_val = LAST; end else w_en = 1'b1;
      S_W1:    if (w_tc) begin w_ld = 1'b1; w_ld_val = LAST; end else w_en = 1'b1;
      S_R1:    if (r_drain || w_tc) w_ld = 1'b1; else w_en = 1'b1;
      default: w_ld = 1'b1;
    endcase
  end

  bist_addr_gen #(.ADDR_W(ADDR_W), .LAST(DEPTH - 1)) u_addr (
    .clk        (CLK),
    .rst        (RST),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_en       (w_en),
    .i_up       (w_up),
    .o_addr     (w_addr),
    .o_tc       (w_tc)
  );

  assign w_miss    = r_cmp_vld && (bus.mem_Q != r_exp_data);
  assign w_err_nxt = (w_miss && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_drain    <= 1'b0;
      r_first    <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_wen      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_pat      <= '0;
      r_data     <= '0;
      r_exp_data <= '0;
      r_exp_addr <= '0;
      r_fail     <= '0;
      r_err      <= '0;
    end else begin
      // Compare runs independent of state so the last R0 read lands in W1.
      r_err     <= w_err_nxt;
      r_cmp_vld <= 1'b0;
      if (w_miss && !r_first) begin
        r_fail  <= r_exp_addr;
        r_first <= 1'b1;
      end
      unique case (r_state)
        S_IDLE, S_FIN: if (bus.start) begin
          r_state <= S_W0;
          r_pat   <= bus.pattern;
          r_wen   <= 1'b1;
          r_data  <= bus.pattern;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
          r_err   <= '0;
          r_fail  <= '0;
          r_first <= 1'b0;
        end
        S_W0: if (w_tc) begin
          r_state <= S_R0;
          r_wen   <= 1'b0;
          r_data  <= '0;
        end
        S_R0: begin
          r_cmp_vld  <= 1'b1;
          r_exp_data <= r_pat;
          r_exp_addr <= w_addr;
          if (w_tc) begin
            r_state <= S_W1;
            r_wen   <= 1'b1;
            r_data  <= ~r_pat;
          end
        end
        S_W1: if (w_tc) begin
          r_state <= S_R1;
          r_wen   <= 1'b0;
          r_data  <= '0;
        end
        S_R1: begin
          if (r_drain) begin
            r_state <= S_FIN;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_cmp_vld  <= 1'b1;
            r_exp_data <= ~r_pat;
            r_exp_addr <= w_addr;
            if (w_tc) r_drain <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_WEN   = r_wen;
  assign bus.mem_Addr  = w_addr;
  assign bus.mem_Data  = r_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_addr = r_fail;
endmodule

// File: doc/spr_bist_ctrl.md
SPR_BIST_CTRL -- requirements
Module: spr_bist_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of memory words tested.
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run the test; sampled only in IDLE or FIN.
REQ-006 pattern  input  DATA_W  background value; captured on the accepted start edge.
REQ-007 mem_WEN  output  1  memory write enable, active-high (1 = write, 0 = read).
REQ-008 mem_Addr  output  4  memory address.
REQ-009 mem_Data  output  DATA_W  memory write data.
REQ-010 mem_Q  input  DATA_W  memory read data, valid one cycle after the read address is issued.
REQ-011 busy  output  1  high from the accepted start until FIN is entered.
REQ-012 done  output  1  high while in FIN.
REQ-013 pass  output  1  high in FIN when err_count == 0.
REQ-014 err_count  output  5  number of miscompares, saturating at 31.
REQ-015 fail_addr  output  4  address of the first miscompare; 0 when no miscompare has occurred.

Function
REQ-016 States: IDLE, W0, R0, W1, R1, FIN.
REQ-017 IDLE/FIN with start=1 -> W0; capture pattern; clear err_count, fail_addr and the first-fail flag.
REQ-018 W0: mem_WEN=1; Addr ascends 0..15; mem_Data=pattern; 16 cycles; then go to R0.
REQ-019 R0: mem_WEN=0; Addr ascends 0..15; expected value=pattern; 16 cycles; then go to W1.
REQ-020 W1: mem_WEN=1; Addr descends 15..0; mem_Data=~pattern; 16 cycles; then go to R1.
REQ-021 R1: mem_WEN=0; Addr descends 15..0; expected value=~pattern; 16 cycles; then go to FIN via one drain cycle, with mem_WEN=0 during the drain.
REQ-022 Compare pipeline:
- Each read issue loads cmp_vld, exp_data and exp_addr registers.
- On the next cycle, mem_Q is compared with exp_data.
- The last R0 compare overlaps the first W1 cycle and is still evaluated.
REQ-023 On a miscompare, err_count increments, saturating at 31.
REQ-024 On the first miscompare of a run, fail_addr is loaded with exp_addr and is then held until the next start.
REQ-025 Timing from the start-accept edge (edge 0):
- W0 issues on cycles 1-16.
- R0 issues on cycles 17-32.
- W1 issues on cycles 33-48.
- R1 issues on cycles 49-64.
- The final compare occurs on cycle 65.
- done=1 from cycle 66.
REQ-026 start is ignored while busy=1.
REQ-027 done, pass, err_count and fail_addr hold in FIN until the next accepted start.
REQ-028 In IDLE and FIN, mem_WEN=0, mem_Addr=0 and mem_Data=0.
REQ-029 Address counters wrap internally without overflow; terminal count is 15 ascending and 0 descending.

Reset
REQ-030 RST=1 forces, immediately and asynchronously:
- state=IDLE
- mem_WEN=0, mem_Addr=0, mem_Data=0
- busy=0, done=0, pass=0
- err_count=0, fail_addr=0
- cmp_vld=0
REQ-031 RST asserted mid-run aborts the test; no partial result is reported, and after release the block waits in IDLE for start.

Structure
REQ-032 Package spr_bist_pkg holds the state enumeration, ADDR_W=4, DEPTH=16, DATA_W=8 and ERR_MAX=31.
REQ-033 One sub-module, bist_addr_gen, provides the up/down 4-bit address counter with load, enable, direction and terminal-count output.

Verification
REQ-034 Bench instantiates spr_bist_ctrl with spr_16x8 (CLK shared, WEN/Addr/Data/Q connected), uses CLK period 20, and checks every requirement with cycle-exact assertions.
REQ-035 Scenario: healthy RAM, pattern=8'h55, start pulse -> done at cycle 66, pass=1, err_count=0, fail_addr=0.
REQ-036 Scenario: memory model with bit 0 stuck at 1 on address 3, pattern=8'h00:
- Required: pass=0 and err_count=1.
- Required: fail_addr=3.
- The W1 background (~pattern=FF) has bit 0 at 1, so the stuck-at-1 fault is detected only in R0.
REQ-037 Scenario: all addresses stuck at 8'hFF, pattern=8'hA5 -> err_count=31 (saturated), fail_addr=0, pass=0.
REQ-038 Scenario: RST pulsed during R0 (cycle 20) -> all outputs 0 immediately; a new start then completes with pass=1.
REQ-039 Scenario: start re-pulsed at cycle 30 -> ignored, done still at cycle 66; start in FIN -> results cleared and a new run begins.
